// File: rtl/alu_issue_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_pkg
// Shared definitions for the ALU operand issue stage:
//   - occ_state_e : buffer occupancy state (EMPTY / ONE / FULL)
//   - DEF_W/DEF_OPW : default operand and opcode widths
//   - alu_entry_t : packed {op, a, b} entry at the default widths
//   - level_of()  : occupancy count encoded for the level output
// ---------------------------------------------------------------------------
package alu_issue_pkg;

    localparam int DEF_W   = 32;
    localparam int DEF_OPW = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [DEF_OPW-1:0] op;
        logic [DEF_W-1:0]   a;
        logic [DEF_W-1:0]   b;
    } alu_entry_t;

    // Occupancy count reported on the level output for a given state.
    function automatic logic [1:0] level_of(input occ_state_e st);
        logic [1:0] lvl;
        case (st)
            ST_EMPTY: lvl = 2'd0;
            ST_ONE:   lvl = 2'd1;
            ST_FULL:  lvl = 2'd2;
            default:  lvl = 2'd0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// ---------------------------------------------------------------------------
// operand_fwd_mux
// Per-operand 2:1 select between the register-read operand and the ALUOut
// feedback value. Build option: ALU_ISSUE_FORWARD_EN. When it is undefined
// the block is a pass-through of data and sel/fb are ignored.
// Ports:
//   sel  : take fb instead of data
//   fb   : ALUOut register value
//   data : operand from register read
//   y    : selected operand
// ---------------------------------------------------------------------------
module operand_fwd_mux
    import alu_issue_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         sel,
    input  logic [W-1:0] fb,
    input  logic [W-1:0] data,
    output logic [W-1:0] y
);

`ifdef ALU_ISSUE_FORWARD_EN
    // Forwarding build: feedback value replaces the operand when selected.
    always_comb begin
        y = data;
        if (sel) begin
            y = fb;
        end else begin
            y = data;
        end
    end
`else
    // Non-forwarding build: sel and fb are kept on the port list but unused.
    logic unused_s;
    assign unused_s = sel ^ (^fb);

    // Pass the register-read operand straight through.
    always_comb begin
        y = data;
    end
`endif

endmodule

// File: rtl/alu_operand_issue.sv
// ---------------------------------------------------------------------------
// alu_operand_issue
// Two-entry operand buffer feeding the ALU, with registered outputs.
// Build option: ALU_ISSUE_FORWARD_EN (operand forwarding from aluout_fb).
// Ports:
//   clock, reset_n     : clock, asynchronous active-low reset
//   flush              : synchronous clear of all buffered entries
//   in_valid/in_ready  : upstream handshake (in_ready depends on state only)
//   in_a, in_b, in_op  : operands and opcode of the incoming entry
//   in_fwd_a, in_fwd_b : substitute aluout_fb for the operand at capture
//   aluout_fb          : ALUOut register output, sampled at the accept edge
//   out_valid/out_ready: handshake toward the ALU
//   out_a, out_b, out_op: head entry, stable while stalled
//   level              : occupancy 0..2
// ---------------------------------------------------------------------------
module alu_operand_issue
    import alu_issue_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int OPW = DEF_OPW
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic [OPW-1:0] in_op,
    input  logic           in_fwd_a,
    input  logic           in_fwd_b,
    input  logic [W-1:0]   aluout_fb,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_a,
    output logic [W-1:0]   out_b,
    output logic [OPW-1:0] out_op,
    output logic [1:0]     level
);

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
    } entry_t;

    occ_state_e state_r;
    entry_t     head_r;
    entry_t     tail_r;
    entry_t     cap_s;
    logic       in_ready_r;
    logic       out_valid_r;
    logic [1:0] level_r;
    logic [W-1:0] cap_a_s;
    logic [W-1:0] cap_b_s;
    logic       push_s;
    logic       pop_s;

    operand_fwd_mux #(.W(W)) u_mux_a (
        .sel  (in_fwd_a),
        .fb   (aluout_fb),
        .data (in_a),
        .y    (cap_a_s)
    );

    operand_fwd_mux #(.W(W)) u_mux_b (
        .sel  (in_fwd_b),
        .fb   (aluout_fb),
        .data (in_b),
        .y    (cap_b_s)
    );

    assign cap_s  = {in_op, cap_a_s, cap_b_s};
    // Handshakes use the registered status flags, so no input reaches an output.
    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign level     = level_r;
    assign out_a     = head_r.a;
    assign out_b     = head_r.b;
    assign out_op    = head_r.op;

    // Occupancy FSM, head/tail entry registers and registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_EMPTY;
            head_r      <= '0;
            tail_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            level_r     <= level_of(ST_EMPTY);
        end else if (flush) begin
            // Entries are discarded; data registers keep their contents.
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            level_r     <= level_of(ST_EMPTY);
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        head_r      <= cap_s;
                        state_r     <= ST_ONE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b1;
                        level_r     <= level_of(ST_ONE);
                    end else begin
                        state_r     <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        // Head leaves this edge, so the new entry takes its place.
                        head_r      <= cap_s;
                        state_r     <= ST_ONE;
                    end else if (push_s) begin
                        tail_r      <= cap_s;
                        state_r     <= ST_FULL;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        level_r     <= level_of(ST_FULL);
                    end else if (pop_s) begin
                        state_r     <= ST_EMPTY;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        level_r     <= level_of(ST_EMPTY);
                    end else begin
                        state_r     <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        head_r      <= tail_r;
                        state_r     <= ST_ONE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b1;
                        level_r     <= level_of(ST_ONE);
                    end else begin
                        state_r     <= ST_FULL;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    level_r     <= level_of(ST_EMPTY);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed and randomized bench for alu_operand_issue with a queue-based model.
module tb_alu_operand_issue;

`ifdef ALU_ISSUE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_op;
    logic        in_fwd_a;
    logic        in_fwd_b;
    logic [31:0] aluout_fb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_op;
    logic [1:0]  level;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];

    alu_operand_issue dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_fwd_a  (in_fwd_a),
        .in_fwd_b  (in_fwd_b),
        .aluout_fb (aluout_fb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .level     (level)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: a FIFO of depth two; a flush empties it and drops any push.
    task automatic model_edge();
        ent_t e;
        bit   push;
        bit   pop;
        push = in_valid && (q.size() < 2);
        pop  = (q.size() > 0) && out_ready;
        e.op = in_op;
        e.a  = (FWD && in_fwd_a) ? aluout_fb : in_a;
        e.b  = (FWD && in_fwd_b) ? aluout_fb : in_b;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, q.size() < 2});
        chk({tag, ".level"},     {30'd0, level},     q.size());
        if (q.size() > 0) begin
            chk({tag, ".out_a"},  out_a, q[0].a);
            chk({tag, ".out_b"},  out_b, q[0].b);
            chk({tag, ".out_op"}, {28'd0, out_op}, {28'd0, q[0].op});
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic rdy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = rdy;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_fwd_a = 1'b0; in_fwd_b = 1'b0;
        aluout_fb = 32'd0;
        drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        #12;
        check_all("reset");
        chk("reset.out_a", out_a, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Streaming with out_ready high: one entry per cycle, level stays 1.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i, 32'h100 + i, i[3:0], 1'b1);
            cycle("stream");
            chk("stream.a", out_a, i);
            chk("stream.level", {30'd0, level}, 32'd1);
        end
        drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        cycle("drain");

        // Backpressure: two entries fill the buffer, head holds.
        drive(1'b1, 32'h11, 32'h21, 4'd1, 1'b0);
        cycle("bp1");
        drive(1'b1, 32'h12, 32'h22, 4'd2, 1'b0);
        cycle("bp2");
        chk("bp.level2", {30'd0, level}, 32'd2);
        chk("bp.in_ready0", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h13, 32'h23, 4'd3, 1'b0);
        cycle("bp3");
        chk("bp.head_stable", out_a, 32'h11);
        drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        cycle("bp_pop1");
        chk("bp.second", out_a, 32'h12);
        chk("bp.in_ready1", {31'd0, in_ready}, 32'd1);
        cycle("bp_pop2");

        // Push and pop together in ONE.
        drive(1'b1, 32'hAAAA, 32'h1, 4'd5, 1'b0);
        cycle("pp1");
        drive(1'b1, 32'hBBBB, 32'h2, 4'd6, 1'b1);
        #1;
        chk("pp.before", out_a, 32'hAAAA);
        cycle("pp2");
        chk("pp.after", out_a, 32'hBBBB);
        chk("pp.level", {30'd0, level}, 32'd1);
        drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        cycle("pp3");

        // Flush while FULL with a coincident push attempt.
        drive(1'b1, 32'h31, 32'h41, 4'd7, 1'b0);
        cycle("fl1");
        drive(1'b1, 32'h32, 32'h42, 4'd8, 1'b0);
        cycle("fl2");
        drive(1'b1, 32'h33, 32'h43, 4'd9, 1'b1);
        flush = 1'b1;
        cycle("fl3");
        flush = 1'b0;
        chk("fl.level", {30'd0, level}, 32'd0);
        drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        cycle("fl4");
        chk("fl.never", {31'd0, out_valid}, 32'd0);
        // Flush in ONE with a push that would otherwise be accepted.
        drive(1'b1, 32'h51, 32'h61, 4'd1, 1'b0);
        cycle("fl5");
        drive(1'b1, 32'h52, 32'h62, 4'd2, 1'b0);
        flush = 1'b1;
        cycle("fl6");
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b0);
        cycle("fl7");

        // Forwarding of operand A, then both operands.
        aluout_fb = 32'hDEADBEEF;
        in_fwd_a = 1'b1;
        drive(1'b1, 32'd5, 32'd9, 4'd3, 1'b1);
        cycle("fwd_a");
        chk("fwd.a", out_a, FWD ? 32'hDEADBEEF : 32'd5);
        chk("fwd.b", out_b, 32'd9);
        in_fwd_b = 1'b1;
        cycle("fwd_ab");
        chk("fwd.ab_b", out_b, FWD ? 32'hDEADBEEF : 32'd9);
        in_fwd_a = 1'b0; in_fwd_b = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, 4'($urandom), $urandom_range(0, 2) != 0);
            in_fwd_a  = 1'($urandom);
            in_fwd_b  = 1'($urandom);
            aluout_fb = $urandom;
            flush     = ($urandom_range(0, 19) == 0);
            cycle("rand");
        end
        flush = 1'b0;

        // Reset asserted mid-cycle while FULL takes effect immediately.
        drive(1'b1, 32'h71, 32'h81, 4'd4, 1'b0);
        cycle("rst1");
        drive(1'b1, 32'h72, 32'h82, 4'd5, 1'b0);
        cycle("rst2");
        chk("rst.full", {30'd0, level}, 32'd2);
        #3;
        reset_n = 1'b0;
        #1;
        q.delete();
        check_all("rst_mid");
        chk("rst.out_a", out_a, 32'd0);
        chk("rst.out_b", out_b, 32'd0);
        chk("rst.out_op", {28'd0, out_op}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 4'd0, 1'b1);
        cycle("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
